// File: rtl/muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg : shared definitions for the iterative multiply/divide sequencer.
//   WIDTH / ITER  operand width and number of datapath iterations
//   CNT_W         step counter width
//   DZ_LO         LO value reported on a divide by zero
//   op_e          MULT / MULTU / DIV / DIVU encodings
//   state_e       sequencer states
//   helpers       op classification and conditional absolute value
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [WIDTH-1:0] DZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Divisions have op[1] set.
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    // Signed variants have op[0] clear.
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    // Magnitude of a two's-complement value when en is set, raw value otherwise.
    function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        if (en && v[WIDTH-1]) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if : request/result bus between the CPU controller and the
// multiply/divide sequencer.
//   master : controller side (drives start/op/a/b/cancel)
//   slave  : sequencer side (drives busy/done/hilo_we/hi/lo/dz)
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;

    modport master (
        output start, op, a, b, cancel,
        input  busy, done, hilo_we, hi, lo, dz
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, done, hilo_we, hi, lo, dz
    );
endinterface

// File: rtl/muldiv_seq_step.sv
// ---------------------------------------------------------------------------
// muldiv_step : one iteration of the shared shift-add / restoring-divide
// datapath (purely combinational).
//   i_is_div  1 = divide step, 0 = multiply step
//   i_acc     current 64-bit accumulator
//              multiply: {partial sum, remaining multiplier}
//              divide  : {partial remainder, dividend/quotient bits}
//   i_opnd    multiplicand (multiply) or divisor (divide), unsigned magnitude
//   i_lsb     multiplier LSB (i_acc[0]) deciding whether to add
//   o_acc     accumulator after this iteration
// ---------------------------------------------------------------------------
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_lsb,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    // Next accumulator for a single multiply or divide iteration.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
        // Shifted partial remainder needs WIDTH+1 bits before the trial subtract.
        w_trial = i_acc[2*WIDTH-1:WIDTH-1];
        w_diff  = w_trial - {1'b0, i_opnd};
        o_acc   = i_acc;
        if (i_is_div) begin
            // No borrow: keep the difference and shift in a 1 quotient bit.
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (i_lsb) begin
                w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
            end else begin
                w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
            end
            // Carry out of the add becomes the new MSB after the right shift.
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : iterative MULT/MULTU/DIV/DIVU sequencer.
//   clk    clock, rising edge
//   rst    asynchronous active-low reset
//   mdbus  slave side of muldiv_seq_if:
//            start/op/a/b  request, sampled in IDLE or DONE
//            cancel        synchronous abort back to IDLE
//            busy          PREP/RUN/FIX in progress
//            done/hilo_we  one-cycle result-valid pulse
//            hi/lo/dz      registered result, updated on entry to DONE
// ---------------------------------------------------------------------------
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave mdbus
);

    state_e             r_state;
    op_e                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dz;

    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_accept;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (op_is_div(r_op)),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .i_lsb    (r_acc[0]),
        .o_acc    (w_acc_next)
    );

    assign w_abs_a  = abs_if(r_a, op_is_signed(r_op));
    assign w_abs_b  = abs_if(r_b, op_is_signed(r_op));
    // Cancel wins over a simultaneous start.
    assign w_accept = mdbus.start & ~mdbus.cancel;

    // Sign fix-up of the raw unsigned result, applied when leaving FIX.
    always_comb begin
        w_prod   = r_acc;
        w_fix_hi = r_acc[2*WIDTH-1:WIDTH];
        w_fix_lo = r_acc[WIDTH-1:0];
        if (op_is_div(r_op)) begin
            w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end else begin
            w_prod   = r_neg_q ? -r_acc : r_acc;
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // Sequencer FSM with datapath registers and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_PREP;
                        r_op    <= op_e'(mdbus.op);
                        r_a     <= mdbus.a;
                        r_b     <= mdbus.b;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (mdbus.cancel) begin
                        r_state <= S_IDLE;
                    end else if (op_is_div(r_op) && (r_b == '0)) begin
                        // Divide by zero: report raw dividend, no iterations.
                        r_state <= S_DONE;
                        r_hi    <= r_a;
                        r_lo    <= DZ_LO;
                        r_dz    <= 1'b1;
                    end else begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_neg_q <= op_is_signed(r_op) & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                        r_neg_r <= op_is_signed(r_op) & op_is_div(r_op) & r_a[WIDTH-1];
                        if (op_is_div(r_op)) begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                    end
                end
                S_RUN: begin
                    if (mdbus.cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == CNT_W'(ITER - 1)) begin
                            r_state <= S_FIX;
                        end else begin
                            r_state <= S_RUN;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    if (mdbus.cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        r_hi    <= w_fix_hi;
                        r_lo    <= w_fix_lo;
                        r_dz    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status decoded from the state register only; no input-to-output path.
    assign mdbus.busy    = (r_state == S_PREP) || (r_state == S_RUN) || (r_state == S_FIX);
    assign mdbus.done    = (r_state == S_DONE);
    assign mdbus.hilo_we = (r_state == S_DONE);
    assign mdbus.hi      = r_hi;
    assign mdbus.lo      = r_lo;
    assign mdbus.dz      = r_dz;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq : directed-vector bench for muldiv_seq. Stimulus pushes the
// hand-computed result and its expected done cycle into a queue; a monitor
// pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_err;
    exp_t sb_q[$];

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq dut (
        .clk   (clk),
        .rst   (rst),
        .mdbus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to time-stamp start edges and done cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                chk("dz", {63'd0, bus.dz}, {63'd0, e.dz});
                chk("hilo_we", {63'd0, bus.hilo_we}, 64'd1);
                chk("busy_with_done", {63'd0, bus.busy}, 64'd0);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Caller is at a negedge; start is sampled at the next posedge (edge E).
    // Result cycle n (1-based) is visible at the negedge after edge E+n-1.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int done_cycle, output int e_edge);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e_edge    = cyc + 1;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.dz  = edz;
            e.cyc = e_edge + done_cycle - 1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 200;
        while (sb_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sb_q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int e;
        cyc        = 0;
        n_chk      = 0;
        n_err      = 0;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        bus.cancel = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hilo_we", {63'd0, bus.hilo_we}, 64'd0);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_dz", {63'd0, bus.dz}, 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // MULTU max*max with busy profile over cycles 1..35.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, e);
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", n), {63'd0, bus.busy}, (n <= 34) ? 64'd1 : 64'd0);
        end
        drain("multu_max");

        // Directed vectors: op, a, b, hi, lo, dz, done cycle.
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35, e);
        drain("mult_neg");
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, e);
        drain("div_neg");
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, e);
        drain("div_wrap");
        issue(2'b11, 32'd100, 32'd0, 1'b1, 32'd100, 32'hFFFF_FFFF, 1'b1, 2, e);
        drain("divu_zero");
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b0, 35, e);
        drain("mult_min");
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 35, e);
        drain("mult_m1");
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 35, e);
        drain("div_negb");
        issue(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 35, e);
        drain("divu_one");
        issue(2'b10, 32'hFFFF_FFF8, 32'd0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, 2, e);
        drain("div_zero");
        issue(2'b01, 32'd0, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 35, e);
        drain("multu_zero");

        // Back-to-back: DIVU 100/7, stray start in cycle 10, MULTU 6x7 in DONE cycle.
        begin
            int e0;
            int e2;
            issue(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 35, e0);
            wait_cyc(e0 + 9);
            bus.start = 1'b1;
            bus.op    = 2'b01;
            bus.a     = 32'd9;
            bus.b     = 32'd9;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            wait_cyc(e0 + 34);
            issue(2'b01, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0, 35, e2);
            chk("b2b_start_edge", 64'(e2), 64'(e0 + 35));
            @(negedge clk);
            chk("b2b_busy_after_done", {63'd0, bus.busy}, 64'd1);
            drain("b2b");
        end

        // Cancel in cycle 20 of a MULT: no done, result registers hold.
        issue(2'b00, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 35, e);
        wait_cyc(e + 19);
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        chk("cancel_busy", {63'd0, bus.busy}, 64'd0);
        chk("cancel_hi", {32'd0, bus.hi}, 64'd0);
        chk("cancel_lo", {32'd0, bus.lo}, 64'd42);
        repeat (40) @(negedge clk);
        chk("cancel_idle_busy", {63'd0, bus.busy}, 64'd0);

        // Reset in cycle 15 of a DIVU: immediate clear, no done after release.
        issue(2'b11, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 35, e);
        wait_cyc(e + 14);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_done", {63'd0, bus.done}, 64'd0);
        chk("midrst_hi", {32'd0, bus.hi}, 64'd0);
        chk("midrst_lo", {32'd0, bus.lo}, 64'd0);
        chk("midrst_dz", {63'd0, bus.dz}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        chk("postrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("postrst_lo", {32'd0, bus.lo}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer serving the multi-cycle CPU's MULT, MULTU, DIV and DIVU instructions. The main controller pulses `start` with an opcode and two operands. The block then sequences one shared 32-step shift-add/shift-subtract datapath, holds `busy` while the operation runs, and delivers a 64-bit HI/LO result with a one-cycle `done`/`hilo_we` pulse. The controller stays in its last state while `busy` is high.

## Interface
- `WIDTH`, 32: operand width. HI, LO and the iteration count all equal `WIDTH`.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request pulse. Sampled only in IDLE or DONE.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `a`  in  WIDTH  rs operand (multiplicand / dividend). Sampled with `start`.
- `b`  in  WIDTH  rt operand (multiplier / divisor). Sampled with `start`.
- `cancel`  in  1  synchronous abort (exception flush).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: the result is valid.
- `hilo_we`  out  1  HI/LO write enable. Identical to `done`.
- `hi`  out  WIDTH  product[63:32] or remainder.
- `lo`  out  WIDTH  product[31:0] or quotient.
- `dz`  out  1  the last division had a zero divisor. Valid with `done`.

## Operation
- States: IDLE, PREP, RUN, FIX, DONE.
  - IDLE: on `start`, go to PREP.
  - PREP: latch `op`, take |a| and |b| for signed ops, record the result signs, clear the step counter.
    - If the op is a division and b==0, go straight to DONE.
    - Otherwise go to RUN.
  - RUN: one iteration per cycle. After 32 iterations (counter reaches 31), go to FIX.
  - FIX: apply the signs, then go to DONE.
  - DONE: with `start`, go to PREP. Otherwise go to IDLE.
- Multiply (shift-add): 64-bit accumulator of 32-bit partial sum plus multiplier register. Each step adds the multiplicand when the multiplier LSB is 1, then shifts right.
  - MULT: negate the 64-bit product when sign(a)≠sign(b).
- Divide (restoring): 64-bit {remainder, quotient} register. Each step shifts left by one, trial-subtracts the divisor and sets the quotient bit when there is no borrow.
  - DIV: the quotient is negative when the signs differ. The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0. This is a natural wrap, with no trap.
- Divide by zero: hi=a (raw), lo=0xFFFFFFFF, dz=1. For multiplies, and for nonzero divisors, dz=0.
- `hi`/`lo`/`dz` are registered. They update only on entry to DONE and hold until the next DONE.
- `start` in PREP/RUN/FIX is ignored. There is no queuing.
- `cancel` in PREP/RUN/FIX or DONE goes to IDLE on the next edge.
  - When cancelled in PREP/RUN/FIX, no `done`, and `hi`/`lo`/`dz` stay unchanged.
  - When cancelled in DONE, the DONE cycle's outputs still occur.
  - `cancel` takes priority over `start` in the same cycle.

## Timing
- Reset (async, takes effect immediately): state=IDLE, busy=0, done=0, hilo_we=0, dz=0, hi=0, lo=0, counter=0.
- Cycle numbering: `start` is sampled at edge 0.
  - Cycle 1 is PREP, cycles 2–33 are RUN, cycle 34 is FIX, cycle 35 is DONE.
  - `busy`=1 in cycles 1–34. `done`=`hilo_we`=1 in cycle 35 only.
- Divide by zero: PREP in cycle 1, DONE in cycle 2. `busy`=1 in cycle 1 only.
- Back-to-back: `start` in the DONE cycle enters PREP at the next edge with no idle gap, so `busy` rises in the cycle right after `done`.
- `busy` and `done` are never high together. Both are decoded from the registered state, with no combinational input-to-output path.
- Reset asserted mid-RUN: everything clears immediately. After release, the block idles until a new `start`.

## Structure
- Package `muldiv_pkg`:
  - op encodings `OP_MULT`/`OP_MULTU`/`OP_DIV`/`OP_DIVU`
  - state enum
  - `ITER`=32
  - `DZ_LO`=32'hFFFF_FFFF
- One combinational sub-module, `muldiv_step`: given op class, the accumulator, the multiplicand/divisor and the LSB, it produces the next accumulator for one iteration.
- The FSM, counter, sign logic and output registers live in `muldiv_seq` (around 200 lines total).

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → cycle 35: done=1, hi=0xFFFFFFFE, lo=0x00000001. busy=1 in cycles 1–34.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, dz=0.
- DIVU a=100, b=0 → done in cycle 2, dz=1, hi=100, lo=0xFFFFFFFF.
- DIVU 100/7 followed by `start` MULTU 6×7 in the DONE cycle, plus an extra `start` pulse in cycle 10 → hi=2, lo=14. Then the second op gives done at cycle 70, hi=0, lo=42. The cycle-10 `start` is ignored.
- `cancel` at cycle 20 of a MULT → IDLE next edge, no done, hi/lo unchanged. `rst`=0 at cycle 15 of another op → outputs 0 immediately, with no done after release.
